// File: rtl/mux_scan.sv
// mux_scan: N-channel, W-bit registered multiplexer with a valid/ready
// handshake on every input and on the output. The channel comes either
// from sel_i (manual mode) or from a round-robin scan over the channels
// that have pending data (scan mode).
// Optional feature: define MUX_SCAN_PARITY_EN to add out_par_o, the
// registered even parity of out_data_o.
module mux_scan #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N*W-1:0] in_data_i,
  input  logic [N-1:0]   in_valid_i,
  output logic [N-1:0]   in_ready_o,
  input  logic           mode_i,
  input  logic [SW-1:0]  sel_i,
  output logic [W-1:0]   out_data_o,
  output logic [SW-1:0]  out_ch_o,
  output logic           out_valid_o,
  input  logic           out_ready_i
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic           out_par_o
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  // One extra bit so that ptr + offset cannot overflow before the wrap.
  localparam logic [SW:0] NUM = (SW+1)'(N);

  state_e        state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] ch;
  logic          ch_vld;
  logic [W-1:0]  ch_word;
  logic          cap, xfer;
`ifdef MUX_SCAN_PARITY_EN
  logic          par_q, par_d;
`endif

  // Channel choice: sel_i in manual mode, first valid channel from ptr in scan mode.
  always_comb begin
    logic [SW:0] idx;
    ch_vld = 1'b0;
    ch     = '0;
    idx    = '0;
    if (!mode_i) begin
      if ({1'b0, sel_i} < NUM) begin
        ch_vld = 1'b1;
        ch     = sel_i;
      end
    end else begin
      // Walk from the farthest offset down so the closest valid channel wins.
      for (int i = N-1; i >= 0; i--) begin
        idx = {1'b0, ptr_q} + (SW+1)'(i);
        if (idx >= NUM) idx = idx - NUM;
        if (in_valid_i[idx[SW-1:0]]) begin
          ch_vld = 1'b1;
          ch     = idx[SW-1:0];
        end
      end
    end
  end

  // Word of the chosen channel.
  always_comb begin
    ch_word = '0;
    for (int c = 0; c < N; c++)
      if (ch == SW'(c)) ch_word = in_data_i[c*W +: W];
  end

  // Space exists when empty or when the held word drains this cycle.
  // rst_i gates it so no producer sees ready while reset is asserted.
  assign cap        = (state_q == EMPTY || out_ready_i) && ch_vld && !rst_i;
  assign xfer       = cap && in_valid_i[ch];
  assign in_ready_o = cap ? ({{(N-1){1'b0}}, 1'b1} << ch) : '0;

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state: capture on transfer, otherwise drain when the consumer takes the word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
`ifdef MUX_SCAN_PARITY_EN
    par_d   = par_q;
`endif
    if (xfer) begin
      state_d = FULL;
      data_d  = ch_word;
      ch_d    = ch;
`ifdef MUX_SCAN_PARITY_EN
      par_d   = ^ch_word;
`endif
      // Only scan mode advances the pointer, past the channel just served.
      if (mode_i) ptr_d = (ch == SW'(N-1)) ? '0 : ch + SW'(1);
    end else if (state_q == FULL && out_ready_i) begin
      state_d = EMPTY;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;
`ifdef MUX_SCAN_PARITY_EN
  assign out_par_o   = par_q;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: a 4-channel instance carries the main scenarios and
// scoreboard; a 6-channel instance covers select values beyond N.
module tb_mux_scan;
  localparam int N = 4, W = 8, SW = 2;
  localparam int N2 = 6, SW2 = 3;

  logic           clk = 1'b0, rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0, in_ready;
  logic           mode = 1'b0, out_valid, out_ready = 1'b0;
  logic [SW-1:0]  sel = '0, out_ch;
  logic [W-1:0]   out_data;

  logic [N2*W-1:0] in_data2 = '0;
  logic [N2-1:0]   in_valid2 = '1, in_ready2;
  logic [SW2-1:0]  sel2 = '0, out_ch2;
  logic [W-1:0]    out_data2;
  logic            out_valid2;
`ifdef MUX_SCAN_PARITY_EN
  logic            out_par, out_par2;
`endif

  typedef struct packed {logic [W-1:0] d; logic [SW-1:0] c;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mux_scan #(.N(N), .W(W)) dut (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .mode_i(mode), .sel_i(sel), .out_data_o(out_data),
    .out_ch_o(out_ch), .out_valid_o(out_valid), .out_ready_i(out_ready)
`ifdef MUX_SCAN_PARITY_EN
    , .out_par_o(out_par)
`endif
  );

  mux_scan #(.N(N2), .W(W)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data2), .in_valid_i(in_valid2),
    .in_ready_o(in_ready2), .mode_i(1'b0), .sel_i(sel2), .out_data_o(out_data2),
    .out_ch_o(out_ch2), .out_valid_o(out_valid2), .out_ready_i(1'b1)
`ifdef MUX_SCAN_PARITY_EN
    , .out_par_o(out_par2)
`endif
  );

  task automatic test_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
    n_chk++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      n_fail++; $display("FAIL rst_outs: got v=%b d=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch); end
    @(posedge clk); #1;
    rst = 1'b0; mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00_00_A5_00; out_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_fill_ready: got %b want 0010", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd1) begin
      n_fail++; $display("FAIL rst_full: got v=%b d=%h ch=%0d want 1/a5/1", out_valid, out_data, out_ch); end
    rst = 1'b1; #1;
    n_chk++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      n_fail++; $display("FAIL rst_async: got v=%b d=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch); end
    n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_async_ready: got %b want 0000", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; mode = 1'b1; in_valid = 4'b1111;
    @(negedge clk);
    n_chk++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr0: got %b want 0001", in_ready); end
    in_valid = 4'b0000; mode = 1'b0; sel = 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_manual();
    exp_t e;
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = 4'b0100; in_data = 32'h11_3C_22_33;
    @(negedge clk);
    n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL man_ready: got %b want 0100", in_ready); end
    sb.push_back({8'h3C, 2'd2});
    @(posedge clk); #1;
    in_valid = 4'b0000;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL man_valid: got %b want 1", out_valid); end
    if (out_valid && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL man_sb: unexpected word %h ch %0d", out_data, out_ch); end
      else begin e = sb.pop_front();
        if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL man_word: got %h/%0d want %h/%0d", out_data, out_ch, e.d, e.c); end end
    end
    n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL man_ready_novalid: got %b want 0100", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || out_data !== 8'h3C || out_ch !== 2'd2) begin
      n_fail++; $display("FAIL man_drain: got v=%b d=%h ch=%0d want 0/3c/2", out_valid, out_data, out_ch); end
    sel2 = 3'd6; #1;
    n_chk++; if (in_ready2 !== 6'b000000) begin n_fail++; $display("FAIL man_sel6: got %b want 000000", in_ready2); end
    sel2 = 3'd7; #1;
    n_chk++; if (in_ready2 !== 6'b000000) begin n_fail++; $display("FAIL man_sel7: got %b want 000000", in_ready2); end
    sel2 = 3'd5; #1;
    n_chk++; if (in_ready2 !== 6'b100000) begin n_fail++; $display("FAIL man_sel5: got %b want 100000", in_ready2); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b0; in_data = 32'h44_33_22_11;
    @(negedge clk);
    n_chk++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_ready: got %b want 0001", in_ready); end
    sb.push_back({8'h11, 2'd0});
    @(posedge clk); #1;
    in_data = 32'h44_33_22_99;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h ch=%0d want 1/11/0", k, out_valid, out_data, out_ch); end
      n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_noready%0d: got %b want 0000", k, in_ready); end
      if (k == 2) begin sel = 2'd3; mode = 1'b1; end
      if (k == 3) mode = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL bp_sb: unexpected word %h ch %0d", out_data, out_ch); end
      else begin e = sb.pop_front();
        if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL bp_word: got %h/%0d want %h/%0d", out_data, out_ch, e.d, e.c); end end
    end
    n_chk++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release: got %b want 1000", in_ready); end
    sb.push_back({8'h44, 2'd3});
    @(posedge clk); #1;
    in_valid = 4'b0000;
    @(negedge clk);
    n_chk++;
    if (!(out_valid && out_ready) || sb.size() == 0) begin n_fail++; $display("FAIL bp_second: got v=%b want 1", out_valid); end
    else begin e = sb.pop_front();
      if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL bp_word2: got %h/%0d want %h/%0d", out_data, out_ch, e.d, e.c); end end
    @(posedge clk); #1;
  endtask

  task automatic test_scan_rr();
    exp_t e;
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    for (int c = 0; c < N; c++) in_data[c*W +: W] = 8'hC0 + 8'(c);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_tput%0d: got %b want 1", k, out_valid); end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rr_sb: unexpected word %h ch %0d", out_data, out_ch); end
        else begin e = sb.pop_front();
          if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL rr_word%0d: got %h/%0d want %h/%0d", k, out_data, out_ch, e.d, e.c); end end
      end
      n_chk++; if (in_ready !== 4'(1 << (k % N))) begin n_fail++; $display("FAIL rr_ready%0d: got %b want %b", k, in_ready, 4'(1 << (k % N))); end
      sb.push_back({8'hC0 + 8'(k % N), 2'(k % N)});
      @(posedge clk); #1;
    end
    in_valid = 4'b0000;
    for (int t = 0; t < 4 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_chk++; e = sb.pop_front();
        if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL rr_drain: got %h/%0d want %h/%0d", out_data, out_ch, e.d, e.c); end
      end
      @(posedge clk); #1;
    end
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL rr_timeout: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_scan_skip_wrap();
    exp_t e;
    logic [N-1:0]  iv [4] = '{4'b0100, 4'b0010, 4'b1001, 4'b1001};
    logic [N-1:0]  ir [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};
    logic [SW-1:0] ec [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    logic [W-1:0]  ed [4] = '{8'h52, 8'h61, 8'h83, 8'h70};
    mode = 1'b1; out_ready = 1'b1; in_data = 32'h83_52_61_70;
    for (int k = 0; k < 4; k++) begin
      in_valid = iv[k];
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL sw_sb: unexpected word %h ch %0d", out_data, out_ch); end
        else begin e = sb.pop_front();
          if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL sw_word%0d: got %h/%0d want %h/%0d", k, out_data, out_ch, e.d, e.c); end end
      end
      n_chk++; if (in_ready !== ir[k]) begin n_fail++; $display("FAIL sw_ready%0d: got %b want %b", k, in_ready, ir[k]); end
      sb.push_back({ed[k], ec[k]});
      @(posedge clk); #1;
    end
    in_valid = 4'b0000;
    for (int t = 0; t < 4 && sb.size() > 0; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_chk++; e = sb.pop_front();
        if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL sw_drain: got %h/%0d want %h/%0d", out_data, out_ch, e.d, e.c); end
      end
      @(posedge clk); #1;
    end
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sw_timeout: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_parity();
`ifdef MUX_SCAN_PARITY_EN
    exp_t e;
    mode = 1'b0; sel = 2'd0; out_ready = 1'b1; in_valid = 4'b0001; in_data = 32'h00_00_00_07;
    @(negedge clk);
    sb.push_back({8'h07, 2'd0});
    @(posedge clk); #1;
    in_data = 32'h00_00_00_03;
    @(negedge clk);
    n_chk++; if (out_par !== 1'b1) begin n_fail++; $display("FAIL par_07: got %b want 1", out_par); end
    n_chk++; e = sb.pop_front();
    if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL par_word07: got %h/%0d want %h/%0d", out_data, out_ch, e.d, e.c); end
    sb.push_back({8'h03, 2'd0});
    @(posedge clk); #1;
    in_valid = 4'b0000;
    @(negedge clk);
    n_chk++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL par_03: got %b want 0", out_par); end
    n_chk++; e = sb.pop_front();
    if (out_data !== e.d || out_ch !== e.c) begin n_fail++; $display("FAIL par_word03: got %h/%0d want %h/%0d", out_data, out_ch, e.d, e.c); end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_manual();
    test_backpressure();
    test_scan_rr();
    test_scan_skip_wrap();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100000");
    $fatal(1);
  end

endmodule
